memory_bus: RTL and testbench
=============================

# memory_bus

Data-memory subsystem for the Hack CPU: decodes the CPU's data-memory address, holds data RAM and a screen shadow RAM, and latches the current keyboard code. Every screen write is also posted through a small FIFO to the video output stage over a valid/ready handshake. It sits directly downstream of the CPU's memory port and supplies the CPU's `mem_rdata`.

## Interface
Parameters:
- `RAM_WORDS`, default 16384: implemented data RAM depth. Range 1..16384.
- `FIFO_DEPTH`, default 4: screen write FIFO depth. Power of two, ≥2.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-low reset (`reset == 0` resets on the next rising edge).
- `mem_address`  in  16  CPU data address.
- `mem_write`  in  1  CPU write strobe; committed at the rising edge where it is high.
- `mem_wdata`  in  16  CPU write data.
- `mem_rdata`  out  16  registered read data for the `mem_address` sampled at the previous edge.
- `key_valid`  in  1  one-cycle keyboard event strobe.
- `key_code`  in  16  key code for the event; 0 means the key was released.
- `scr_wvalid`  out  1  FIFO head valid toward the video stage.
- `scr_waddr`  out  13  screen word offset (`address - 0x4000`).
- `scr_wdata`  out  16  screen word data.
- `scr_wready`  in  1  video stage accepts the head when `scr_wvalid && scr_wready`.
- `scr_overflow`  out  1  sticky flag: a screen write was dropped because the FIFO was full.

## Operation
Address decode of `mem_address`:
- 0x0000–0x3FFF: data RAM.
  - Offsets ≥ `RAM_WORDS` read 0.
  - Writes to those offsets are ignored.
- 0x4000–0x5FFF: screen.
  - 8192-word shadow RAM, readable and writable.
  - Every write is also pushed to the FIFO.
- 0x6000: keyboard register.
  - Read-only; writes are ignored.
- 0x6001–0xFFFF: reads return 0; writes are ignored.

Reads:
- `mem_rdata` is registered from the address presented at each edge.
- Read is write-first: if `mem_write` targets the same address in the same cycle, `mem_rdata` returns `mem_wdata`.

Keyboard:
- On `key_valid`, the keyboard register is loaded with `key_code`.
- It holds that value until the next event.

Screen FIFO:
- Each entry is {13-bit offset, 16-bit data}.
- Occupancy counter runs 0..`FIFO_DEPTH`; read and write pointers wrap modulo `FIFO_DEPTH`.
- Push on a screen write. The push is accepted if the FIFO is not full, or if a pop occurs in the same cycle.
- If the push is not accepted: the shadow RAM is still updated, the FIFO is unchanged, and `scr_overflow` is set.
- Pop when `scr_wvalid && scr_wready`.
- `scr_wvalid` = (count != 0).
- `scr_waddr` and `scr_wdata` show the head entry and hold stable while `scr_wvalid && !scr_wready`.
- `scr_overflow` clears only on reset.

Reset (`reset == 0` at an edge):
- `mem_rdata` = 0.
- Keyboard register = 0.
- FIFO emptied: count = 0, pointers = 0, so `scr_wvalid` = 0.
- `scr_overflow` = 0.
- RAM and shadow-RAM contents are not cleared.
- A write or `key_valid` in the reset cycle is discarded.
- Reset mid-handshake drops all FIFO entries.

## Timing
- Read latency: 1 cycle. An address presented in cycle N yields data valid after edge N+1. This matches the CPU: address stable in fetch, data sampled in decode.
- Writes commit at the edge where `mem_write` = 1. A read of the same address in the next cycle returns the new data.
- Keyboard: a `key_valid` at edge N is visible in `mem_rdata` for a read presented at edge N+1 or later. A read presented at edge N returns the old value.
- FIFO:
  - A push at edge N raises `scr_wvalid` after edge N, when the FIFO was empty.
  - Throughput is one pop per cycle.
  - Push and pop in the same cycle with count = `FIFO_DEPTH` leaves count unchanged; the push is accepted and the flag is not set.
- All outputs are registered or derived from registered state; there are no combinational paths from inputs to outputs.

## Test plan
- Write 0x1234 to 0x0010, then read 0x0010 → `mem_rdata` = 0x1234 one cycle later. Read 0x6005 → 0.
- Same-cycle write 0xBEEF and read at 0x0020 → `mem_rdata` = 0xBEEF. Write 0xAAAA to 0x6000 → keyboard register unchanged.
- `key_valid` with `key_code` = 0x0041, then read 0x6000 → 0x0041. Event with code 0, then read → 0x0000.
- `scr_wready` = 0, 5 writes to 0x4000..0x4004 with `FIFO_DEPTH` = 4 →
  - `scr_overflow` = 1.
  - Shadow reads of all 5 return their written data.
  - Then `scr_wready` = 1 drains offsets 0,1,2,3 in order, after which `scr_wvalid` = 0.
- FIFO full with `scr_wready` = 1 and a simultaneous write to 0x5FFF → push accepted, `scr_overflow` stays 0, last entry drained is offset 0x1FFF.
- FIFO holding 2 entries, `scr_overflow` = 1, drive `reset` = 0 for one cycle → `scr_wvalid` = 0, `scr_overflow` = 0, `mem_rdata` = 0, keyboard = 0, earlier RAM data still readable.

Source files
------------

// File: rtl/memory_bus.sv
// memory_bus: Hack data-memory decode (RAM, screen shadow RAM + screen write FIFO, keyboard latch); CPU port mem_*, keyboard key_*, video port scr_*
module memory_bus #(
  parameter int RAM_WORDS  = 16384,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] mem_address,
  input  logic        mem_write,
  input  logic [15:0] mem_wdata,
  output logic [15:0] mem_rdata,
  input  logic        key_valid,
  input  logic [15:0] key_code,
  output logic        scr_wvalid,
  output logic [12:0] scr_waddr,
  output logic [15:0] scr_wdata,
  input  logic        scr_wready,
  output logic        scr_overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int RIW = RAM_WORDS > 1 ? $clog2(RAM_WORDS) : 1;
  localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);
  logic [15:0] ram [RAM_WORDS];
  logic [15:0] shadow [8192];
  logic [12:0] fifo_a [FIFO_DEPTH];
  logic [15:0] fifo_d [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0] count;
  logic [15:0] kbd, rd_next;
  logic [RIW-1:0] ram_idx;
  logic ram_hit, scr_hit, kbd_hit, pop, push, accept;
  assign ram_idx = mem_address[RIW-1:0];
  assign ram_hit = mem_address[15:14] == 2'b00 && 32'(mem_address[13:0]) < RAM_WORDS;
  assign scr_hit = mem_address[15:13] == 3'b010;
  assign kbd_hit = mem_address == 16'h6000;
  assign pop = scr_wvalid && scr_wready;
  assign push = reset && mem_write && scr_hit;
  assign accept = push && (count != FULL || pop);
  assign scr_wvalid = count != '0;
  assign scr_waddr = fifo_a[rd_ptr];
  assign scr_wdata = fifo_d[rd_ptr];
  always_comb rd_next = mem_write && (ram_hit || scr_hit) ? mem_wdata :
                        ram_hit ? ram[ram_idx] :
                        scr_hit ? shadow[mem_address[12:0]] :
                        kbd_hit ? kbd : 16'h0000;
  always_ff @(posedge clk) begin
    if (reset && mem_write && ram_hit) ram[ram_idx] <= mem_wdata;
    if (push) shadow[mem_address[12:0]] <= mem_wdata;
    if (accept) begin
      fifo_a[wr_ptr] <= mem_address[12:0];
      fifo_d[wr_ptr] <= mem_wdata;
    end
    if (!reset) begin
      mem_rdata    <= '0;
      kbd          <= '0;
      count        <= '0;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      scr_overflow <= 1'b0;
    end else begin
      mem_rdata <= rd_next;
      if (key_valid) kbd <= key_code;
      count <= count + (AW+1)'(accept) - (AW+1)'(pop);
      if (accept) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      if (push && !accept) scr_overflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_memory_bus.sv
// tb_memory_bus: randomized scoreboard bench for memory_bus against a queue/array reference model
module tb_memory_bus;
  localparam int RW = 1000;
  localparam int D = 4;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [15:0] mem_address = '0;
  logic mem_write = 1'b0;
  logic [15:0] mem_wdata = '0;
  logic [15:0] mem_rdata;
  logic key_valid = 1'b0;
  logic [15:0] key_code = '0;
  logic scr_wvalid;
  logic [12:0] scr_waddr;
  logic [15:0] scr_wdata;
  logic scr_wready = 1'b0;
  logic scr_overflow;
  always #5 clk = ~clk;
  memory_bus #(.RAM_WORDS(RW), .FIFO_DEPTH(D)) dut (
    .clk(clk), .reset(reset), .mem_address(mem_address), .mem_write(mem_write),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .key_valid(key_valid), .key_code(key_code),
    .scr_wvalid(scr_wvalid), .scr_waddr(scr_waddr), .scr_wdata(scr_wdata),
    .scr_wready(scr_wready), .scr_overflow(scr_overflow)
  );
  typedef struct {int due; logic chk; logic [15:0] rd; logic ovf; logic flush;} rexp_t;
  typedef struct {int due; logic [12:0] a; logic [15:0] d;} sexp_t;
  rexp_t rq[$];
  sexp_t sq[$];
  logic [15:0] ref_ram [16384];
  logic known [16384];
  logic [15:0] ref_scr [8192];
  logic kscr [8192];
  logic [15:0] kref = '0;
  logic ovf_ref = 1'b0;
  int mocc = 0;
  int cyc = 0;
  int checks = 0;
  int fails = 0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string n, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %h expected %h", n, cyc, got, exp);
    end
  endtask
  task automatic step(input logic rn, input logic we, input logic [15:0] a, input logic [15:0] wd,
                      input logic kv, input logic [15:0] kc, input logic wr);
    rexp_t r;
    sexp_t s;
    logic pop, acc, sw;
    @(posedge clk);
    #1;
    reset = rn; mem_write = we; mem_address = a; mem_wdata = wd;
    key_valid = kv; key_code = kc; scr_wready = wr;
    r.due = cyc + 1;
    r.flush = !rn;
    r.chk = 1'b1;
    sw = we && a >= 16'h4000 && a < 16'h6000;
    if (!rn) r.rd = 16'h0;
    else if (we && (a < RW || sw)) r.rd = wd;
    else if (a < RW) begin r.rd = ref_ram[a[13:0]]; r.chk = known[a[13:0]]; end
    else if (a < 16'h4000) r.rd = 16'h0;
    else if (a < 16'h6000) begin r.rd = ref_scr[a[12:0]]; r.chk = kscr[a[12:0]]; end
    else if (a == 16'h6000) r.rd = kref;
    else r.rd = 16'h0;
    if (!rn) begin
      kref = '0;
      ovf_ref = 1'b0;
      mocc = 0;
    end else begin
      if (kv) kref = kc;
      if (we && a < RW) begin ref_ram[a[13:0]] = wd; known[a[13:0]] = 1'b1; end
      if (sw) begin ref_scr[a[12:0]] = wd; kscr[a[12:0]] = 1'b1; end
      pop = mocc != 0 && wr;
      acc = sw && (mocc < D || pop);
      mocc = mocc - int'(pop) + int'(acc);
      if (acc) begin s.due = cyc + 1; s.a = a[12:0]; s.d = wd; sq.push_back(s); end
      if (sw && !acc) ovf_ref = 1'b1;
    end
    r.ovf = ovf_ref;
    rq.push_back(r);
  endtask
  always @(negedge clk) begin
    rexp_t r;
    sexp_t s;
    logic hv;
    if (cyc >= 1) begin
      while (rq.size() != 0 && rq[0].due <= cyc) begin
        r = rq.pop_front();
        if (r.flush) sq = sq.find with (item.due > cyc);
        if (r.chk) chk("mem_rdata", mem_rdata, r.rd);
        chk("scr_overflow", 16'(scr_overflow), 16'(r.ovf));
      end
      hv = sq.size() != 0 && sq[0].due <= cyc;
      chk("scr_wvalid", 16'(scr_wvalid), 16'(hv));
      if (hv && scr_wready) begin
        s = sq.pop_front();
        chk("scr_waddr", 16'(scr_waddr), 16'(s.a));
        chk("scr_wdata", scr_wdata, s.d);
      end
    end
  end
  initial begin
    logic [15:0] a;
    for (int i = 0; i < 16384; i++) known[i] = 1'b0;
    for (int i = 0; i < 8192; i++) kscr[i] = 1'b0;
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 16'h0010, 16'h5555, 1, 16'h0099, 0);
    step(1, 1, 16'h0010, 16'h1234, 0, 0, 0);
    step(1, 0, 16'h0010, 0, 0, 0, 0);
    step(1, 0, 16'h6005, 0, 0, 0, 0);
    step(1, 1, 16'h0020, 16'hBEEF, 0, 0, 0);
    step(1, 1, 16'h6000, 16'hAAAA, 0, 0, 0);
    step(1, 0, 16'h6000, 0, 0, 0, 0);
    step(1, 0, 16'h6000, 0, 1, 16'h0041, 0);
    step(1, 0, 16'h6000, 0, 0, 0, 0);
    step(1, 0, 16'h6000, 0, 1, 16'h0000, 0);
    step(1, 0, 16'h6000, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 1, 16'(16'h4000 + i), 16'(16'hC000 + i), 0, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 0, 16'(16'h4000 + i), 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) step(1, 0, 16'h0010, 0, 0, 0, 1);
    step(1, 1, 16'h4010, 16'h1111, 0, 0, 0);
    step(1, 1, 16'h4011, 16'h2222, 1, 16'h0033, 0);
    step(0, 0, 16'h0010, 0, 0, 0, 0);
    step(1, 0, 16'h0010, 0, 0, 0, 0);
    step(1, 0, 16'h6000, 0, 0, 0, 0);
    step(1, 0, 16'h4011, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 1, 16'(16'h4100 + i), 16'(16'hD000 + i), 0, 0, 0);
    step(1, 1, 16'h5FFF, 16'h7777, 0, 0, 1);
    for (int i = 0; i < 6; i++) step(1, 0, 16'h5FFF, 0, 0, 0, 1);
    step(1, 1, 16'(RW - 1), 16'h0ABC, 0, 0, 0);
    step(1, 1, 16'(RW), 16'h0DEF, 0, 0, 0);
    step(1, 0, 16'(RW - 1), 0, 0, 0, 0);
    step(1, 0, 16'(RW), 0, 0, 0, 0);
    step(1, 0, 16'h3FFF, 0, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 6))
        0: a = 16'($urandom_range(0, 63));
        1: a = 16'($urandom_range(RW - 4, RW + 4));
        2: a = 16'(16'h4000 + $urandom_range(0, 31));
        3: a = 16'(16'h5FF0 + $urandom_range(0, 15));
        4: a = 16'h6000;
        5: a = 16'(16'h6001 + $urandom_range(0, 16'h9FFE));
        default: a = 16'($urandom);
      endcase
      step($urandom_range(0, 199) != 0, 1'($urandom), a, 16'($urandom),
           $urandom_range(0, 7) == 0, 16'($urandom), $urandom_range(0, 2) != 0);
    end
    for (int i = 0; i < 8; i++) step(1, 0, 16'h6000, 0, 0, 0, 1);
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
